// File: rtl/reg_file_sb_pkg.sv
// reg_file_pkg: shared defaults, types and constants for the reg_file_sb register file.
//   DATA_W_DEF / ADDR_W_DEF : default word and address widths
//   data_t / addr_t         : default-width data word and register address
//   ZERO_ADDR               : address of the hardwired zero register
package reg_file_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    typedef logic [DATA_W_DEF-1:0] data_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;
    localparam addr_t ZERO_ADDR = '0;
endpackage

// File: rtl/reg_file_sb_rdport.sv
// reg_file_sb_rdport: one combinational read port with zero-register mask, busy lookup and optional write bypass.
//   addr                 : read address
//   regs / busy_vec      : current storage and scoreboard state
//   we0/wa0/wd0, we1/wa1/wd1 : this cycle's write ports (enables already qualified by the top)
//   iss_en / iss_addr    : this cycle's issue (already qualified)
//   rdata / busy         : read data and scoreboard bit for addr
// Macro REG_FILE_SB_BYPASS_EN enables same-cycle forwarding of write data and busy clearing.
module reg_file_sb_rdport
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     regs [2**ADDR_W],
    input  logic [2**ADDR_W-1:0]  busy_vec,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     wa0,
    input  logic [DATA_W-1:0]     wd0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     wa1,
    input  logic [DATA_W-1:0]     wd1,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy
);
`ifdef REG_FILE_SB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    logic hit0, hit1, hit_iss, is_zero;
    always_comb begin
        hit0    = we0 && (wa0 == addr);
        hit1    = we1 && (wa1 == addr);
        hit_iss = iss_en && (iss_addr == addr);
        is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(ZERO_ADDR));
        // port 0 forwards over port 1, mirroring storage priority
        rdata   = is_zero ? '0 : (BYPASS && hit0) ? wd0 : (BYPASS && hit1) ? wd1 : regs[addr];
        // a completing write hides busy unless a new issue to the same register lands on the same edge
        busy    = !is_zero && busy_vec[addr] && !(BYPASS && (hit0 || hit1) && !hit_iss);
    end
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read / 2-write register file with per-register busy scoreboard.
//   clk, rst (async active-high)
//   ra/rb -> read_a/read_b, busy_a/busy_b : combinational read ports
//   we0/wa0/wd0 : ALU writeback (wins collisions); we1/wa1/wd1 : load writeback
//   iss_en/iss_addr : mark destination busy; any_busy : OR of stored busy bits
// Macro REG_FILE_SB_BYPASS_EN enables same-cycle write forwarding in the read ports.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra,
    input  logic [ADDR_W-1:0] rb,
    output logic [DATA_W-1:0] read_a,
    output logic [DATA_W-1:0] read_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              any_busy
);
    localparam int DEPTH = 2**ADDR_W;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic              we0_v, we1_v, iss_v;
    always_comb begin
        // accesses to the hardwired zero register are dropped here so storage and scoreboard never see them
        we0_v  = we0 && !((ZERO_REG != 0) && (wa0 == ADDR_W'(ZERO_ADDR)));
        we1_v  = we1 && !((ZERO_REG != 0) && (wa1 == ADDR_W'(ZERO_ADDR)));
        iss_v  = iss_en && !((ZERO_REG != 0) && (iss_addr == ADDR_W'(ZERO_ADDR)));
        regs_d = regs_q;
        busy_d = busy_q;
        // port 1 first so port 0 overwrites it on a collision; both still count as completions
        if (we1_v) begin
            regs_d[wa1] = wd1;
            busy_d[wa1] = 1'b0;
        end
        if (we0_v) begin
            regs_d[wa0] = wd0;
            busy_d[wa0] = 1'b0;
        end
        // issue applied last: a new op supersedes a completing one
        if (iss_v) busy_d[iss_addr] = 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end
    assign any_busy = |busy_q;
    reg_file_sb_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rd_a (
        .addr(ra), .regs(regs_q), .busy_vec(busy_q),
        .we0(we0_v), .wa0(wa0), .wd0(wd0), .we1(we1_v), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_v), .iss_addr(iss_addr), .rdata(read_a), .busy(busy_a)
    );
    reg_file_sb_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rd_b (
        .addr(rb), .regs(regs_q), .busy_vec(busy_q),
        .we0(we0_v), .wa0(wa0), .wd0(wd0), .we1(we1_v), .wa1(wa1), .wd1(wd1),
        .iss_en(iss_v), .iss_addr(iss_addr), .rdata(read_b), .busy(busy_b)
    );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard-driven self-checking bench for reg_file_sb (default parameters).
module tb_reg_file_sb;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ra, rb, wa0, wa1, iss_addr;
    logic [7:0] read_a, read_b, wd0, wd1;
    logic       busy_a, busy_b, we0, we1, iss_en, any_busy;
    int         checks = 0;
    int         fails  = 0;
    logic [7:0] exp_q [$];
    logic [7:0] e;
    logic [7:0] mem [16];
    logic [15:0] mb;
`ifdef REG_FILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    reg_file_sb dut (
        .clk(clk), .rst(rst), .ra(ra), .rb(rb), .read_a(read_a), .read_b(read_b),
        .busy_a(busy_a), .busy_b(busy_b), .we0(we0), .wa0(wa0), .wd0(wd0),
        .we1(we1), .wa1(wa1), .wd1(wd1), .iss_en(iss_en), .iss_addr(iss_addr),
        .any_busy(any_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; iss_en = 0;
        wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; iss_addr = 0;
    endtask

    function automatic logic [7:0] m_read(input logic [3:0] a);
        if (a == 0) return 8'h00;
        if (BYP && we0 && wa0 == a) return wd0;
        if (BYP && we1 && wa1 == a) return wd1;
        return mem[a];
    endfunction

    function automatic logic m_busy(input logic [3:0] a);
        if (a == 0) return 1'b0;
        if (BYP && ((we0 && wa0 == a) || (we1 && wa1 == a)) && !(iss_en && iss_addr == a)) return 1'b0;
        return mb[a];
    endfunction

    task automatic test_reset();
        rst = 1; idle(); ra = 3; rb = 4;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        tick(); tick();
        e = exp_q.pop_front(); checks++;
        if (read_a !== e) begin fails++; $display("FAIL reset_init read_a got %h exp %h", read_a, e); end
        e = exp_q.pop_front(); checks++;
        if ({7'b0, any_busy} !== e) begin fails++; $display("FAIL reset_init any_busy got %b exp %b", any_busy, e[0]); end
        rst = 0;
        tick();
        we0 = 1; wa0 = 3; wd0 = 8'h5A; iss_en = 1; iss_addr = 4;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h01);
        tick(); idle();
        e = exp_q.pop_front(); checks++;
        if (read_a !== e) begin fails++; $display("FAIL reset_write read_a got %h exp %h", read_a, e); end
        e = exp_q.pop_front(); checks++;
        if ({7'b0, any_busy} !== e) begin fails++; $display("FAIL reset_write any_busy got %b exp %b", any_busy, e[0]); end
        #2 rst = 1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        #1;
        e = exp_q.pop_front(); checks++;
        if (read_a !== e) begin fails++; $display("FAIL reset_async read_a got %h exp %h", read_a, e); end
        e = exp_q.pop_front(); checks++;
        if ({7'b0, busy_b} !== e) begin fails++; $display("FAIL reset_async busy_b got %b exp %b", busy_b, e[0]); end
        e = exp_q.pop_front(); checks++;
        if ({7'b0, any_busy} !== e) begin fails++; $display("FAIL reset_async any_busy got %b exp %b", any_busy, e[0]); end
        tick();
        we0 = 1; wa0 = 3; wd0 = 8'h77; iss_en = 1; iss_addr = 6;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        tick(); idle();
        e = exp_q.pop_front(); checks++;
        if (read_a !== e) begin fails++; $display("FAIL reset_hold read_a got %h exp %h", read_a, e); end
        e = exp_q.pop_front(); checks++;
        if ({7'b0, any_busy} !== e) begin fails++; $display("FAIL reset_hold any_busy got %b exp %b", any_busy, e[0]); end
        rst = 0;
        tick();
    endtask

    task automatic test_zero_reg();
        ra = 0;
        we0 = 1; wa0 = 0; wd0 = 8'hFF; iss_en = 1; iss_addr = 0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        #1;
        e = exp_q.pop_front(); checks++;
        if (read_a !== e) begin fails++; $display("FAIL zero_same read_a got %h exp %h", read_a, e); end
        e = exp_q.pop_front(); checks++;
        if ({7'b0, busy_a} !== e) begin fails++; $display("FAIL zero_same busy_a got %b exp %b", busy_a, e[0]); end
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            tick(); idle();
            e = exp_q.pop_front(); checks++;
            if (read_a !== e) begin fails++; $display("FAIL zero_after read_a got %h exp %h", read_a, e); end
            e = exp_q.pop_front(); checks++;
            if ({7'b0, busy_a} !== e) begin fails++; $display("FAIL zero_after busy_a got %b exp %b", busy_a, e[0]); end
            e = exp_q.pop_front(); checks++;
            if ({7'b0, any_busy} !== e) begin fails++; $display("FAIL zero_after any_busy got %b exp %b", any_busy, e[0]); end
        end
    endtask

    task automatic test_collision();
        rb = 5;
        we0 = 1; wa0 = 5; wd0 = 8'h11; we1 = 1; wa1 = 5; wd1 = 8'h22;
        exp_q.push_back(8'h11);
        tick(); idle();
        e = exp_q.pop_front(); checks++;
        if (read_b !== e) begin fails++; $display("FAIL collision read_b got %h exp %h", read_b, e); end
    endtask

    task automatic test_scoreboard();
        ra = 7;
        iss_en = 1; iss_addr = 7;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h01);
        tick(); idle();
        e = exp_q.pop_front(); checks++;
        if ({7'b0, busy_a} !== e) begin fails++; $display("FAIL sb_issue busy_a got %b exp %b", busy_a, e[0]); end
        e = exp_q.pop_front(); checks++;
        if ({7'b0, any_busy} !== e) begin fails++; $display("FAIL sb_issue any_busy got %b exp %b", any_busy, e[0]); end
        we1 = 1; wa1 = 7; wd1 = 8'h3C;
        exp_q.push_back(BYP ? 8'h3C : 8'h00);
        exp_q.push_back(BYP ? 8'h00 : 8'h01);
        #1;
        e = exp_q.pop_front(); checks++;
        if (read_a !== e) begin fails++; $display("FAIL sb_complete_same read_a got %h exp %h", read_a, e); end
        e = exp_q.pop_front(); checks++;
        if ({7'b0, busy_a} !== e) begin fails++; $display("FAIL sb_complete_same busy_a got %b exp %b", busy_a, e[0]); end
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        tick(); idle();
        e = exp_q.pop_front(); checks++;
        if (read_a !== e) begin fails++; $display("FAIL sb_complete read_a got %h exp %h", read_a, e); end
        e = exp_q.pop_front(); checks++;
        if ({7'b0, busy_a} !== e) begin fails++; $display("FAIL sb_complete busy_a got %b exp %b", busy_a, e[0]); end
        e = exp_q.pop_front(); checks++;
        if ({7'b0, any_busy} !== e) begin fails++; $display("FAIL sb_complete any_busy got %b exp %b", any_busy, e[0]); end
    endtask

    task automatic test_issue_complete();
        ra = 9;
        iss_en = 1; iss_addr = 9;
        tick(); idle();
        we1 = 1; wa1 = 9; wd1 = 8'h4B; iss_en = 1; iss_addr = 9;
        exp_q.push_back(8'h01);
        #1;
        e = exp_q.pop_front(); checks++;
        if ({7'b0, busy_a} !== e) begin fails++; $display("FAIL iss_cpl_same busy_a got %b exp %b", busy_a, e[0]); end
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h4B);
        tick(); idle();
        e = exp_q.pop_front(); checks++;
        if ({7'b0, busy_a} !== e) begin fails++; $display("FAIL iss_cpl busy_a got %b exp %b", busy_a, e[0]); end
        e = exp_q.pop_front(); checks++;
        if (read_a !== e) begin fails++; $display("FAIL iss_cpl read_a got %h exp %h", read_a, e); end
        we0 = 1; wa0 = 9; wd0 = 8'h4C;
        tick(); idle();
    endtask

    task automatic test_bypass();
        ra = 2;
        we0 = 1; wa0 = 2; wd0 = 8'h10;
        tick(); idle();
        we0 = 1; wa0 = 2; wd0 = 8'hA5;
        exp_q.push_back(BYP ? 8'hA5 : 8'h10);
        #1;
        e = exp_q.pop_front(); checks++;
        if (read_a !== e) begin fails++; $display("FAIL bypass_same read_a got %h exp %h", read_a, e); end
        exp_q.push_back(8'hA5);
        tick(); idle();
        e = exp_q.pop_front(); checks++;
        if (read_a !== e) begin fails++; $display("FAIL bypass_next read_a got %h exp %h", read_a, e); end
    endtask

    task automatic test_back_to_back();
        #2 rst = 1;
        #1 rst = 0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mb = '0;
        tick();
        for (int n = 0; n < 300; n++) begin
            ra = 4'($urandom); rb = 4'($urandom);
            we0 = 1'($urandom); wa0 = 4'($urandom_range(0, 5)); wd0 = 8'($urandom);
            we1 = 1'($urandom); wa1 = 4'($urandom_range(0, 5)); wd1 = 8'($urandom);
            iss_en = ($urandom_range(0, 2) == 0); iss_addr = 4'($urandom_range(0, 5));
            if (n % 5 == 0) begin ra = wa0; rb = wa1; end
            exp_q.push_back(m_read(ra));
            exp_q.push_back(m_read(rb));
            exp_q.push_back({6'b0, m_busy(ra), m_busy(rb)});
            exp_q.push_back({7'b0, |mb});
            #1;
            e = exp_q.pop_front(); checks++;
            if (read_a !== e) begin fails++; $display("FAIL b2b[%0d] read_a ra=%0d got %h exp %h", n, ra, read_a, e); end
            e = exp_q.pop_front(); checks++;
            if (read_b !== e) begin fails++; $display("FAIL b2b[%0d] read_b rb=%0d got %h exp %h", n, rb, read_b, e); end
            e = exp_q.pop_front(); checks++;
            if ({6'b0, busy_a, busy_b} !== e) begin fails++; $display("FAIL b2b[%0d] busy_ab got %b%b exp %b", n, busy_a, busy_b, e[1:0]); end
            e = exp_q.pop_front(); checks++;
            if ({7'b0, any_busy} !== e) begin fails++; $display("FAIL b2b[%0d] any_busy got %b exp %b", n, any_busy, e[0]); end
            if (we1 && wa1 != 0) begin
                if (!(we0 && wa0 == wa1)) mem[wa1] = wd1;
                mb[wa1] = 1'b0;
            end
            if (we0 && wa0 != 0) begin
                mem[wa0] = wd0;
                mb[wa0] = 1'b0;
            end
            if (iss_en && iss_addr != 0) mb[iss_addr] = 1'b1;
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_zero_reg();
        test_collision();
        test_scoreboard();
        test_issue_complete();
        test_bypass();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
